// File: rtl/key_debounce_if.sv
// key_debounce_if: button-side signal bundle for one debounced key.
//   key_in      raw active-low pad level (into the debouncer)
//   key_out     debounced active-low level (to the key counter)
//   key_press   one-cycle pulse on accepted press
//   key_release one-cycle pulse on accepted release
//   long_press  one-cycle pulse once per long hold
// master: pad / stimulus side.  slave: the debouncer itself.
interface key_debounce_if;
  logic key_in;
  logic key_out;
  logic key_press;
  logic key_release;
  logic long_press;

  modport master (
    output key_in,
    input  key_out,
    input  key_press,
    input  key_release,
    input  long_press
  );

  modport slave (
    input  key_in,
    output key_out,
    output key_press,
    output key_release,
    output long_press
  );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchronises a bouncy active-low button pin and filters it
// with a counter-qualified FSM, producing a clean level plus press, release
// and long-press pulses.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  key_debounce_if.slave (key_in in; key_out, key_press,
//        key_release, long_press out, all registered)
//
// state        | meaning
// IDLE         | released, key_out = 1
// PRESS_WAIT   | low seen, qualifying press with cnt
// DOWN         | press accepted, key_out = 0, hold counting
// RELEASE_WAIT | high seen, qualifying release with cnt, key_out = 0
module key_debounce #(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int LONG_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic          clk,
  input  logic          rst,
  key_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    DOWN         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);

  logic             s1, s2;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] hold, hold_nxt;
  logic             key_out_r, key_out_nxt;
  logic             press_r, press_nxt;
  logic             release_r, release_nxt;
  logic             long_r, long_nxt;
  logic             hold_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= bus.key_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold      <= '0;
      key_out_r <= 1'b1;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold      <= hold_nxt;
      key_out_r <= key_out_nxt;
      press_r   <= press_nxt;
      release_r <= release_nxt;
      long_r    <= long_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hold_nxt    = hold;
    key_out_nxt = key_out_r;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    hold_run    = 1'b0;

    case (state)
      IDLE: begin
        key_out_nxt = 1'b1;
        if (!s2) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (s2) begin
          state_nxt = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_nxt   = DOWN;
          key_out_nxt = 1'b0;
          press_nxt   = 1'b1;
          hold_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DOWN: begin
        key_out_nxt = 1'b0;
        hold_run    = 1'b1;
        if (s2) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!s2) begin
          state_nxt = DOWN;
          hold_run  = 1'b1;
        end else if (cnt == DEB_LAST) begin
          state_nxt   = IDLE;
          key_out_nxt = 1'b1;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt  = cnt + 1'b1;
          hold_run = 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        key_out_nxt = 1'b1;
      end
    endcase

    // The key is still accepted-pressed while a release is being qualified,
    // so hold keeps running there; a bounce back to DOWN neither clears nor
    // delays it. Saturation at LONG_CYCLES makes the pulse fire only once.
    if (hold_run) begin
      if (hold != LONG_MAX) hold_nxt = hold + 1'b1;
      if (hold == LONG_LAST) long_nxt = 1'b1;
    end
  end

  assign bus.key_out     = key_out_r;
  assign bus.key_press   = press_r;
  assign bus.key_release = release_r;
  assign bus.long_press  = long_r;

endmodule
